// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with sync, blank, colour and frame-start outputs.
// Define VGA_TIMING_TESTPATTERN_EN to replace the flat background with eight vertical colour bars.
module vga_timing #(
  parameter int          H_VISIBLE = 1024,
  parameter int          H_FRONT   = 24,
  parameter int          H_SYNC    = 136,
  parameter int          H_BACK    = 160,
  parameter int          V_VISIBLE = 768,
  parameter int          V_FRONT   = 3,
  parameter int          V_SYNC    = 6,
  parameter int          V_BACK    = 29,
  parameter logic [11:0] BG_RGB    = 12'h888
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        frame_start
);

  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_ON  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [10:0] h_next, v_next;
  logic        h_wrap, v_wrap;
  logic        hsync_next, hblnk_next, vsync_next, vblnk_next, frame_next;
  logic [11:0] rgb_next;

  // Every output is decoded from the next counter values and registered together,
  // so counters, syncs, blanks and colour always describe the same pixel.
  always_comb begin
    h_wrap     = (hcount_out >= H_LAST);
    v_wrap     = (vcount_out >= V_LAST);
    h_next     = h_wrap ? 11'd0 : hcount_out + 11'd1;
    v_next     = vcount_out;
    if (h_wrap)
      v_next = v_wrap ? 11'd0 : vcount_out + 11'd1;
    frame_next = h_wrap && v_wrap;

    hblnk_next = (h_next >= H_VIS);
    hsync_next = (h_next >= H_SYNC_ON) && (h_next < H_SYNC_OFF);
    vblnk_next = (v_next >= V_VIS);
    vsync_next = (v_next >= V_SYNC_ON) && (v_next < V_SYNC_OFF);

    rgb_next = 12'h000;
    if (!hblnk_next && !vblnk_next) begin
`ifdef VGA_TIMING_TESTPATTERN_EN
      case (h_next[9:7])
        3'd0:    rgb_next = 12'h000;
        3'd1:    rgb_next = 12'hF00;
        3'd2:    rgb_next = 12'h0F0;
        3'd3:    rgb_next = 12'h00F;
        3'd4:    rgb_next = 12'hFF0;
        3'd5:    rgb_next = 12'h0FF;
        3'd6:    rgb_next = 12'hF0F;
        default: rgb_next = 12'hFFF;
      endcase
`else
      rgb_next = BG_RGB;
`endif
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vsync_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      rgb_out     <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= h_next;
      vcount_out  <= v_next;
      hsync_out   <= hsync_next;
      hblnk_out   <= hblnk_next;
      vsync_out   <= vsync_next;
      vblnk_out   <= vblnk_next;
      rgb_out     <= rgb_next;
      frame_start <= frame_next;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for line timing and colours, shrunken instance for frame-level behaviour.
module tb_vga_timing;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  logic [10:0] d_h, d_v, s_h, s_v;
  logic        d_hs, d_hb, d_vs, d_vb, d_fs;
  logic        s_hs, s_hb, s_vs, s_vb, s_fs;
  logic [11:0] d_rgb, s_rgb;

  vga_timing dut_d (
    .pclk(pclk), .rst(rst), .hcount_out(d_h), .vcount_out(d_v),
    .hsync_out(d_hs), .hblnk_out(d_hb), .vsync_out(d_vs), .vblnk_out(d_vb),
    .rgb_out(d_rgb), .frame_start(d_fs)
  );

  // 24 x 15 raster: H 16/2/3/3, V 10/1/2/2, frame = 360 cycles
  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .pclk(pclk), .rst(rst), .hcount_out(s_h), .vcount_out(s_v),
    .hsync_out(s_hs), .hblnk_out(s_hb), .vsync_out(s_vs), .vblnk_out(s_vb),
    .rgb_out(s_rgb), .frame_start(s_fs)
  );

`ifdef VGA_TIMING_TESTPATTERN_EN
  localparam logic [11:0] EXP_BAR0 = 12'h000;
  localparam logic [11:0] EXP_128  = 12'hF00;
  localparam logic [11:0] EXP_1023 = 12'hFFF;
`else
  localparam logic [11:0] EXP_BAR0 = 12'h888;
  localparam logic [11:0] EXP_128  = 12'h888;
  localparam logic [11:0] EXP_1023 = 12'h888;
`endif

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    int hs_cnt, hb_cnt, hs_first, hs_last, hb_first, seq_err;
    int mism, fs_cnt, vs_run, vs_max, guard;
    int fs_t[2];
    int mh, mv;
    logic [10:0] prev;
    logic [11:0] r128, r1023, r1024, erg;
    logic ehb, ehs, evb, evs, efs;

    // ---------------- reset and first line, full-size instance
    rst = 1'b1;
    step(5);
    check("rst_d_all", {d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs, d_rgb}, 64'd0);
    check("rst_s_all", {s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fs, s_rgb}, 64'd0);
    rst = 1'b0;
    step(1);
    check("first_h", d_h, 11'd1);
    check("first_v", d_v, 11'd0);
    check("first_flags", {d_hs, d_hb, d_vs, d_vb, d_fs}, 5'b0);
    check("first_rgb", d_rgb, EXP_BAR0);
    step(1342);
    check("eol_h", d_h, 11'd1343);
    check("eol_v", d_v, 11'd0);
    check("eol_hb", d_hb, 1'b1);
    check("eol_rgb", d_rgb, 12'h000);
    step(1);
    check("wrap_h", d_h, 11'd0);
    check("wrap_v", d_v, 11'd1);
    check("wrap_hb_hs", {d_hb, d_hs}, 2'b00);

    // ---------------- one full line from (0,1)
    hs_cnt = 0; hb_cnt = 0; hs_first = -1; hs_last = -1; hb_first = -1; seq_err = 0;
    r128 = 'x; r1023 = 'x; r1024 = 'x;
    for (int i = 0; i < 1344; i++) begin
      prev = d_h;
      step(1);
      if (int'(d_h) != ((prev == 11'd1343) ? 0 : int'(prev) + 1)) seq_err++;
      if (d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_h);
        hs_last = int'(d_h);
      end
      if (d_hb) begin
        hb_cnt++;
        if (hb_first < 0) hb_first = int'(d_h);
      end
      if (d_h == 11'd128)  r128  = d_rgb;
      if (d_h == 11'd1023) r1023 = d_rgb;
      if (d_h == 11'd1024) r1024 = d_rgb;
    end
    check("line_seq_err", seq_err, 0);
    check("hsync_width", hs_cnt, 136);
    check("hsync_first", hs_first, 1048);
    check("hsync_last", hs_last, 1183);
    check("hblnk_first", hb_first, 1024);
    check("hblnk_width", hb_cnt, 320);
    check("line_end_hv", {d_h, d_v}, {11'd0, 11'd2});
    check("line_end_flags", {d_hb, d_hs}, 2'b00);
    check("rgb_128", r128, EXP_128);
    check("rgb_1023", r1023, EXP_1023);
    check("rgb_1024", r1024, 12'h000);

    // ---------------- frame behaviour, small instance
    rst = 1'b1;
    step(2);
    check("rst2_s_all", {s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fs, s_rgb}, 64'd0);
    rst = 1'b0;
    step(1);
    check("s_first_hv", {s_h, s_v}, {11'd1, 11'd0});
    mh = 1; mv = 0;
    mism = 0; fs_cnt = 0; vs_run = 0; vs_max = 0; fs_t[0] = 0; fs_t[1] = 0;
    for (int c = 1; c <= 800; c++) begin
      step(1);
      if (mh == 23) begin
        mh = 0;
        mv = (mv == 14) ? 0 : mv + 1;
      end else mh++;
      ehb = (mh >= 16);
      ehs = (mh >= 18) && (mh < 21);
      evb = (mv >= 10);
      evs = (mv >= 11) && (mv < 13);
      efs = (mh == 0) && (mv == 0);
      erg = (ehb || evb) ? 12'h000 : EXP_BAR0;
      if ({s_h, s_v, s_hb, s_hs, s_vb, s_vs, s_fs, s_rgb} !==
          {11'(mh), 11'(mv), ehb, ehs, evb, evs, efs, erg}) mism++;
      if (s_fs) begin
        if (fs_cnt < 2) fs_t[fs_cnt] = c;
        fs_cnt++;
      end
      vs_run = s_vs ? vs_run + 1 : 0;
      if (vs_run > vs_max) vs_max = vs_run;
    end
    check("s_model_mism", mism, 0);
    check("s_fs_count", fs_cnt, 2);
    check("s_fs_period", fs_t[1] - fs_t[0], 360);
    check("s_vsync_run", vs_max, 48);

    guard = 0;
    while (!(s_h == 11'd23 && s_v == 11'd14) && guard < 400) begin
      step(1);
      guard++;
    end
    check("s_reach_last", {s_h, s_v}, {11'd23, 11'd14});
    step(1);
    check("s_wrap_hv", {s_h, s_v}, 22'd0);
    check("s_wrap_fs", s_fs, 1'b1);
    check("s_wrap_blank", {s_vb, s_hb}, 2'b00);
    check("s_wrap_rgb", s_rgb, EXP_BAR0);
    step(1);
    check("s_fs_one_cycle", s_fs, 1'b0);

    // ---------------- mid-frame reset at (5,7)
    step(172);
    check("s_mid_pos", {s_h, s_v}, {11'd5, 11'd7});
    rst = 1'b1;
    step(1);
    check("s_midrst_all", {s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fs, s_rgb}, 64'd0);
    check("d_midrst_all", {d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs, d_rgb}, 64'd0);
    rst = 1'b0;
    step(1);
    check("s_resume_hv", {s_h, s_v}, {11'd1, 11'd0});
    check("s_resume_fs", s_fs, 1'b0);
    step(359);
    check("s_resume_frame", {s_h, s_v, s_fs}, {11'd0, 11'd0, 1'b1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VISIBLE, default 1024, active pixels per line.
REQ-002 Parameter H_FRONT, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 160, horizontal back porch in pixels; H_TOTAL = sum = 1344.
REQ-005 Parameter V_VISIBLE, default 768, active lines; V_FRONT default 3; V_SYNC default 6; V_BACK default 29; V_TOTAL = 806.
REQ-006 Parameter BG_RGB, default 12'h888, background colour.
REQ-007 pclk  input  1  pixel clock, all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 hcount_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-010 vcount_out  output  11  current line, 0..V_TOTAL-1.
REQ-011 hsync_out  output  1  horizontal sync, active-high.
REQ-012 hblnk_out  output  1  horizontal blanking, high outside visible columns.
REQ-013 vsync_out  output  1  vertical sync, active-high.
REQ-014 vblnk_out  output  1  vertical blanking, high outside visible lines.
REQ-015 rgb_out  output  12  pixel colour 4:4:4, feeds first draw stage rgb_in.
REQ-016 frame_start  output  1  one-cycle pulse marking pixel (0,0) of a new frame.

Function
REQ-017 All outputs SHALL be registered; all outputs SHALL describe the same pixel in the same cycle (zero skew between counters, sync, blank, rgb).
REQ-018 hcount_out SHALL increment by 1 each pclk cycle and wrap from H_TOTAL-1 (1343) to 0.
REQ-019 vcount_out SHALL increment by 1 exactly in the cycle hcount_out wraps, and wrap from V_TOTAL-1 (805) to 0 on the same cycle hcount_out wraps.
REQ-020 hblnk_out SHALL be high iff hcount_out >= H_VISIBLE (1024..1343).
REQ-021 hsync_out SHALL be high iff H_VISIBLE+H_FRONT <= hcount_out < H_VISIBLE+H_FRONT+H_SYNC (1048..1183).
REQ-022 vblnk_out SHALL be high iff vcount_out >= V_VISIBLE (768..805).
REQ-023 vsync_out SHALL be high iff V_VISIBLE+V_FRONT <= vcount_out < V_VISIBLE+V_FRONT+V_SYNC (771..776), for whole lines including blanked columns.
REQ-024 rgb_out SHALL be 12'h000 whenever hblnk_out or vblnk_out is high.
REQ-025 In visible region rgb_out SHALL be BG_RGB (pattern option per REQ-031).
REQ-026 frame_start SHALL be high for exactly one cycle, the cycle in which counters wrap from (1343,805) to (0,0); low otherwise.
REQ-027 Frame period SHALL be exactly H_TOTAL*V_TOTAL = 1,083,264 cycles between frame_start pulses.
REQ-028 Next-state comparisons SHALL use 11-bit unsigned arithmetic; no counter value outside 0..TOTAL-1 SHALL ever appear.

Reset
REQ-029 While rst is high at a rising edge, every output SHALL be 0 on the following cycle (hcount/vcount 0, syncs/blanks 0, rgb 12'h000, frame_start 0).
REQ-030 On the first rising edge with rst low, hcount_out SHALL become 1, vcount_out stay 0, other outputs per REQ-020..026; rst asserted mid-frame SHALL abort the frame immediately with no frame_start pulse.

Configuration
REQ-031 Macro VGA_TIMING_TESTPATTERN_EN: defined -> visible rgb_out SHALL be 8 vertical colour bars, bar index = hcount_out[9:7], colours in order 000,F00,0F0,00F,FF0,0FF,F0F,FFF; undefined -> visible rgb_out SHALL be BG_RGB and bar logic SHALL not be compiled.

Verification
REQ-032 Release rst after 5 cycles -> first cycle hcount_out=1, vcount_out=0, all flags 0, rgb_out=BG_RGB; 1343 cycles later hcount_out=0, vcount_out=1.
REQ-033 Run one line -> hblnk_out rises at hcount_out=1024, hsync_out high exactly 136 cycles (1048..1183), both low again at hcount_out=0.
REQ-034 Run two frames -> vsync_out high for 6*1344=8064 consecutive cycles at lines 771..776; vblnk_out high lines 768..805; frame_start pulses exactly 1,083,264 cycles apart, coincident with (0,0).
REQ-035 Check (1343,805) -> next cycle (0,0), frame_start=1, vblnk_out=0, hblnk_out=0, rgb_out non-blank.
REQ-036 Assert rst at (500,300) for 1 cycle -> next cycle all outputs 0, no frame_start, counting resumes from hcount_out=1.
REQ-037 With VGA_TIMING_TESTPATTERN_EN defined -> rgb_out=F00 at hcount_out=128, FFF at 1023, 000 at 1024; undefined -> BG_RGB at 128 and 1023.
